// File: rtl/game_sprite_control.sv
// Position generator for a single sprite: integrates a signed velocity once per
// step strobe and parks the sprite once the display stage reports it off screen.
module game_sprite_control #(
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 10,
  parameter int DX_WIDTH     = 4,
  parameter int DY_WIDTH     = 4,
  parameter int STROBE_WIDTH = 20,
  parameter int START_X      = 0,
  parameter int START_Y      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sprite_write_xy,
  input  logic [X_WIDTH-1:0]  sprite_write_x,
  input  logic [Y_WIDTH-1:0]  sprite_write_y,
  input  logic                sprite_write_dxy,
  input  logic [DX_WIDTH-1:0] sprite_write_dx,
  input  logic [DY_WIDTH-1:0] sprite_write_dy,
  input  logic                sprite_enable_update,
  input  logic                sprite_within_screen,
  output logic [X_WIDTH-1:0]  sprite_x,
  output logic [Y_WIDTH-1:0]  sprite_y,
  output logic                running,
  output logic                gone,
  output logic                out_of_screen
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [STROBE_WIDTH-1:0] strobe_cnt;
  logic                    strobe;
  logic [DX_WIDTH-1:0]     dx;
  logic [DY_WIDTH-1:0]     dy;
  logic [X_WIDTH-1:0]      dx_ext;
  logic [Y_WIDTH-1:0]      dy_ext;
  logic                    do_move;
  logic                    do_exit;

  assign strobe = &strobe_cnt;

  // Two's-complement addition of the sign-extended step wraps modulo 2^WIDTH.
  assign dx_ext = {{(X_WIDTH-DX_WIDTH){dx[DX_WIDTH-1]}}, dx};
  assign dy_ext = {{(Y_WIDTH-DY_WIDTH){dy[DY_WIDTH-1]}}, dy};

  // Disable wins over the off-screen check, so both qualify on the enable.
  assign do_move = (state == RUN) && sprite_enable_update && strobe && sprite_within_screen;
  assign do_exit = (state == RUN) && sprite_enable_update && strobe && !sprite_within_screen;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (sprite_enable_update) next_state = RUN;
      RUN: begin
        if (!sprite_enable_update) next_state = IDLE;
        else if (do_exit)          next_state = GONE;
      end
      GONE: begin
        if (sprite_write_xy) next_state = sprite_enable_update ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      strobe_cnt    <= '0;
      sprite_x      <= X_WIDTH'(START_X);
      sprite_y      <= Y_WIDTH'(START_Y);
      dx            <= '0;
      dy            <= '0;
      running       <= 1'b0;
      gone          <= 1'b0;
      out_of_screen <= 1'b0;
    end else begin
      strobe_cnt    <= strobe_cnt + STROBE_WIDTH'(1);
      state         <= next_state;
      running       <= (next_state == RUN);
      gone          <= (next_state == GONE);
      out_of_screen <= do_exit;

      if (sprite_write_dxy) begin
        dx <= sprite_write_dx;
        dy <= sprite_write_dy;
      end

      // A position load overrides any move scheduled for the same edge.
      if (sprite_write_xy) begin
        sprite_x <= sprite_write_x;
        sprite_y <= sprite_write_y;
      end else if (do_move) begin
        sprite_x <= sprite_x + dx_ext;
        sprite_y <= sprite_y + dy_ext;
      end
    end
  end

endmodule

// File: tb/tb_game_sprite_control.sv
// Directed bench for game_sprite_control with a 4-cycle step strobe.
module tb_game_sprite_control;

  logic       clk;
  logic       reset;
  logic       sprite_write_xy;
  logic [9:0] sprite_write_x;
  logic [9:0] sprite_write_y;
  logic       sprite_write_dxy;
  logic [3:0] sprite_write_dx;
  logic [3:0] sprite_write_dy;
  logic       sprite_enable_update;
  logic       sprite_within_screen;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       running;
  logic       gone;
  logic       out_of_screen;

  int n_checks = 0;
  int n_fails  = 0;
  int ph       = 0;

  game_sprite_control #(
    .X_WIDTH(10),
    .Y_WIDTH(10),
    .DX_WIDTH(4),
    .DY_WIDTH(4),
    .STROBE_WIDTH(2),
    .START_X(0),
    .START_Y(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sprite_write_xy(sprite_write_xy),
    .sprite_write_x(sprite_write_x),
    .sprite_write_y(sprite_write_y),
    .sprite_write_dxy(sprite_write_dxy),
    .sprite_write_dx(sprite_write_dx),
    .sprite_write_dy(sprite_write_dy),
    .sprite_enable_update(sprite_enable_update),
    .sprite_within_screen(sprite_within_screen),
    .sprite_x(sprite_x),
    .sprite_y(sprite_y),
    .running(running),
    .gone(gone),
    .out_of_screen(out_of_screen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ph tracks the step counter value during the current cycle (3 = strobe).
  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic to_strobe();
    while (ph != 3) step();
  endtask

  task automatic check_xy(input string tag, input int ex, input int ey);
    check({tag, "_x"}, 32'(sprite_x), 32'(ex));
    check({tag, "_y"}, 32'(sprite_y), 32'(ey));
  endtask

  initial begin
    reset = 1'b0;
    sprite_write_xy = 1'b0;
    sprite_write_x = '0;
    sprite_write_y = '0;
    sprite_write_dxy = 1'b0;
    sprite_write_dx = '0;
    sprite_write_dy = '0;
    sprite_enable_update = 1'b0;
    sprite_within_screen = 1'b1;

    // Reset and single step
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    ph = 0;
    check_xy("rst", 0, 0);
    check("rst_running", 32'(running), 0);
    check("rst_gone", 32'(gone), 0);
    check("rst_oos", 32'(out_of_screen), 0);
    sprite_write_dxy = 1'b1;
    sprite_write_dx = 4'd3;
    sprite_write_dy = 4'b1110;
    sprite_enable_update = 1'b1;
    step();
    sprite_write_dxy = 1'b0;
    check("en_running", 32'(running), 1);
    to_strobe();
    check_xy("pre_step", 0, 0);
    step();
    check_xy("step1", 3, 1022);
    check("step1_running", 32'(running), 1);

    // Multi-step from a loaded position
    sprite_write_xy = 1'b1;
    sprite_write_x = 10'd100;
    sprite_write_y = 10'd200;
    sprite_write_dxy = 1'b1;
    sprite_write_dx = 4'hF;
    sprite_write_dy = 4'd1;
    step();
    sprite_write_xy = 1'b0;
    sprite_write_dxy = 1'b0;
    check_xy("load", 100, 200);
    for (int i = 0; i < 4; i++) begin
      to_strobe();
      check_xy("ms_hold", 100 - i, 200 + i);
      step();
      check_xy("ms_step", 99 - i, 201 + i);
    end
    check_xy("ms_final", 96, 204);

    // Exit and recovery
    to_strobe();
    sprite_within_screen = 1'b0;
    step();
    check_xy("exit_nomove", 96, 204);
    check("exit_gone", 32'(gone), 1);
    check("exit_running", 32'(running), 0);
    check("exit_oos", 32'(out_of_screen), 1);
    step();
    check("exit_oos_pulse", 32'(out_of_screen), 0);
    check("exit_gone_hold", 32'(gone), 1);
    to_strobe();
    step();
    check_xy("gone_frozen", 96, 204);
    sprite_within_screen = 1'b1;
    sprite_write_xy = 1'b1;
    sprite_write_x = 10'd10;
    sprite_write_y = 10'd10;
    step();
    sprite_write_xy = 1'b0;
    check_xy("recover", 10, 10);
    check("recover_running", 32'(running), 1);
    check("recover_gone", 32'(gone), 0);

    // Same-cycle write_xy at a strobe
    sprite_write_dxy = 1'b1;
    sprite_write_dx = 4'd5;
    sprite_write_dy = 4'd0;
    step();
    sprite_write_dxy = 1'b0;
    to_strobe();
    sprite_write_xy = 1'b1;
    sprite_write_x = 10'd50;
    sprite_write_y = 10'd50;
    step();
    sprite_write_xy = 1'b0;
    check_xy("wxy_collide", 50, 50);
    to_strobe();
    step();
    check_xy("wxy_after", 55, 50);

    // Same-cycle write_dxy at a strobe
    sprite_write_dxy = 1'b1;
    sprite_write_dx = 4'd1;
    step();
    sprite_write_dxy = 1'b0;
    to_strobe();
    sprite_write_dxy = 1'b1;
    sprite_write_dx = 4'd7;
    step();
    sprite_write_dxy = 1'b0;
    check_xy("wdxy_old", 56, 50);
    to_strobe();
    step();
    check_xy("wdxy_new", 63, 50);

    // Disable during motion
    sprite_enable_update = 1'b0;
    step();
    check("dis_running", 32'(running), 0);
    check("dis_gone", 32'(gone), 0);
    for (int i = 0; i < 3; i++) begin
      to_strobe();
      step();
      check_xy("dis_hold", 63, 50);
    end
    sprite_enable_update = 1'b1;
    step();
    check("reen_running", 32'(running), 1);
    to_strobe();
    step();
    check_xy("reen_move", 70, 50);

    // Asynchronous mid-run reset between edges
    step();
    #2;
    reset = 1'b0;
    #1;
    check_xy("arst", 0, 0);
    check("arst_running", 32'(running), 0);
    check("arst_gone", 32'(gone), 0);
    check("arst_oos", 32'(out_of_screen), 0);
    #1;
    reset = 1'b1;
    ph = 0;
    step();
    check("arst_reen_running", 32'(running), 1);
    to_strobe();
    step();
    check_xy("arst_nomotion", 0, 0);
    to_strobe();
    step();
    check_xy("arst_nomotion2", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/game_sprite_control.md
# game_sprite_control

Sequential position generator for one sprite, directly upstream of the sprite display stage. Holds the sprite's X/Y position and signed per-step velocity. Advances the position once per internal step strobe and drives `sprite_x`/`sprite_y` into the display stage. Consumes that stage's registered `sprite_within_screen` flag and parks the sprite once it has left the screen.

## Interface

Parameters:
- `X_WIDTH`, 10: X coordinate width in bits.
- `Y_WIDTH`, 10: Y coordinate width in bits.
- `DX_WIDTH`, 4: signed X velocity width.
- `DY_WIDTH`, 4: signed Y velocity width.
- `STROBE_WIDTH`, 20: step-divider counter width; legal minimum 2.
- `START_X`, 0: X position after reset.
- `START_Y`, 0: Y position after reset.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low (0 = reset).
- `sprite_write_xy`  in  1: load position from `sprite_write_x`/`sprite_write_y`.
- `sprite_write_x`  in  X_WIDTH: X value to load.
- `sprite_write_y`  in  Y_WIDTH: Y value to load.
- `sprite_write_dxy`  in  1: load velocity from `sprite_write_dx`/`sprite_write_dy`.
- `sprite_write_dx`  in  DX_WIDTH: signed two's-complement X step.
- `sprite_write_dy`  in  DY_WIDTH: signed two's-complement Y step.
- `sprite_enable_update`  in  1: level; permits motion.
- `sprite_within_screen`  in  1: registered on-screen flag from the display stage.
- `sprite_x`  out  X_WIDTH: current X position (registered).
- `sprite_y`  out  Y_WIDTH: current Y position (registered).
- `running`  out  1: high in state RUN.
- `gone`  out  1: high in state GONE.
- `out_of_screen`  out  1: one-cycle pulse on entry to GONE.

## Operation

- Step strobe:
  - Free-running `STROBE_WIDTH`-bit counter; reset value 0; increments every cycle.
  - `strobe` is high in the cycle where the counter equals all ones, then the counter wraps to 0.
  - Period is 2^STROBE_WIDTH cycles, at least 4.
- Registers:
  - `x`, `y`: position.
  - `dx`, `dy`: velocity, reset 0.
  - `state`.
- States:
  - IDLE (reset state): no motion.
    - `sprite_enable_update`=1 → RUN.
  - RUN: motion active.
    - `sprite_enable_update`=0 → IDLE; takes priority over the out-of-screen check.
    - `strobe`=1 and `sprite_within_screen`=0 → GONE, pulse `out_of_screen`, no move that cycle.
    - `strobe`=1 and `sprite_within_screen`=1 → x <= x + sext(dx), y <= y + sext(dy).
  - GONE: frozen; velocity writes are accepted.
    - `sprite_write_xy`=1 → RUN if `sprite_enable_update`=1, else IDLE.
- Arithmetic:
  - Velocity is sign-extended to X_WIDTH/Y_WIDTH.
  - Sums are truncated modulo 2^X_WIDTH / 2^Y_WIDTH; wrap-around is allowed, with no saturation.
  - Wrap-around is how a sprite leaves the screen to the left or top; the display stage then reports off-screen.
- `sprite_write_xy`:
  - Accepted in any state.
  - Overrides a same-cycle move; the loaded value is not incremented.
  - Does not affect the strobe counter.
- `sprite_write_dxy`:
  - Accepted in any state.
  - A same-cycle move uses the old `dx`/`dy`; new values take effect from the next strobe.
- Step period vs. flag delay:
  - The step period is ≥4 cycles and the display stage delays its flag by 1 cycle.
  - So `sprite_within_screen` at each strobe reflects the current `x`/`y`, except within 1 cycle of a `sprite_write_xy`. The integrator must not write within 1 cycle before a strobe if an exact check is needed.
- Reset: asynchronous, active-low, mid-operation allowed.
  - state=IDLE, `x`=START_X, `y`=START_Y, `dx`=`dy`=0, counter=0.
  - `running`=0, `gone`=0, `out_of_screen`=0, all immediately.

## Timing

- Reset values:
  - `sprite_x`=START_X, `sprite_y`=START_Y.
  - `running`=0, `gone`=0, `out_of_screen`=0.
- Step timing:
  - First strobe falls in cycle 2^STROBE_WIDTH−1 after reset release, counting the first cycle after release as cycle 0.
  - Position change is visible on `sprite_x`/`sprite_y` the cycle after a strobe (1-cycle latency).
- Write latency: `sprite_write_xy` appears on the outputs the next cycle.
- Status outputs:
  - `running` and `gone` are registered decodes of state and change in the same edge as the state.
  - `out_of_screen` is high exactly the one cycle following the GONE transition edge.
- Enable/disable:
  - IDLE→RUN takes effect the cycle after `sprite_enable_update` rises.
  - Motion starts at the next strobe; the counter is not restarted.

## Test plan

Use STROBE_WIDTH=2 (strobe every 4 cycles) and X_WIDTH=Y_WIDTH=10.

- **Reset and single step.** Reset, load dx=3, dy=−2, enable=1, within=1 → `sprite_x`/`sprite_y` = 0/0 then 3/1022 one cycle after the first strobe. `running`=1.
- **Multi-step from a loaded position.** write_xy (100,200), dx=−1, dy=+1, four strobes → (96,204). Values change only the cycle after each strobe.
- **Exit and recovery.** Force within=0 at a strobe → no move, `gone`=1, a single-cycle `out_of_screen`. Further strobes leave the position frozen. write_xy (10,10) with enable=1 → `running`=1.
- **Same-cycle collisions.**
  - write_xy (50,50) in a strobe cycle with dx=5 → outputs 50/50 with no increment.
  - write_dxy dx=7 in a strobe cycle with old dx=1 → +1 now, +7 at the next strobe.
- **Disable during motion.** enable=0 in RUN → IDLE. Position holds across 3 strobes; re-enable resumes from the held value.
- **Mid-operation reset.** Assert reset low mid-run, asynchronously between edges → outputs go to START_X/START_Y, 0, 0, 0 before the next clock edge. dx/dy clear, so re-enable without write_dxy gives no motion.
